// File: rtl/wiznet_stream_pkg.sv
// Shared types and widths for the W5500 UDP streaming scheduler.
// Contents:
//   SAMPLE_W / WORD_W / SAMPLES_PER_WORD : ADC sample packing geometry
//   MAX_UDP_PAYLOAD                      : largest UDP payload in bytes
//   fsm_state_t                          : request sequencer states
package wiznet_stream_pkg;

  localparam int SAMPLE_W         = 12;
  localparam int WORD_W           = 48;
  localparam int SAMPLES_PER_WORD = 4;
  localparam int MAX_UDP_PAYLOAD  = 1472;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PUSH  = 3'd1,
    S_HOLD  = 3'd2,
    S_WAIT  = 3'd3,
    S_FLUSH = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/stream_word_fifo.sv
// Synchronous word FIFO with full/empty flags and a registered read port.
// dout is refreshed from the head slot every clock, so a word written on
// edge N is visible on dout after edge N+1.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   wr_en, din   : write request and data (accepted when not full, or when
//                  a read happens in the same clock)
//   rd_en        : pop the head word (ignored when empty)
//   dout         : registered head word
//   full, empty  : occupancy flags
module stream_word_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // A full FIFO still accepts a write when the head leaves in the same clock.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage is left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      dout <= mem[rd_ptr];
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wiznet_udp_stream_sched.sv
// Streams 12-bit ADC samples to the W5500 interface block as UDP packets.
// Four samples are packed MSB-first into a 48-bit word, buffered in a word
// FIFO, pushed one word per request, and a flush is requested once a packet
// is complete, after an idle timeout, or when streaming stops.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   enable            : streaming enable; low discards a partial word
//   sample_valid      : sample strobe
//   sample            : 12-bit ADC sample
//   overflow_clear    : clears the sticky overflow flag
//   wiz_is_available  : wiznet block idle and ready for a request
//   wiz_data_valid    : one-clock word push pulse
//   wiz_data          : word presented with wiz_data_valid
//   wiz_flush         : one-clock packet flush pulse
//   overflow          : sticky, a packed word was dropped on a full FIFO
//   packets_sent      : number of flushes issued (wraps)
//   busy              : sequencer active or words still buffered
module wiznet_udp_stream_sched
  import wiznet_stream_pkg::*;
#(
  parameter int FIFO_DEPTH       = 16,
  parameter int WORDS_PER_PACKET = 240,
  parameter int FLUSH_TIMEOUT    = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                overflow_clear,
  input  logic                wiz_is_available,
  output logic                wiz_data_valid,
  output logic [WORD_W-1:0]   wiz_data,
  output logic                wiz_flush,
  output logic                overflow,
  output logic [15:0]         packets_sent,
  output logic                busy
);

  localparam int PC_W = $clog2(SAMPLES_PER_WORD);
  localparam int WC_W = $clog2(WORDS_PER_PACKET + 1);
  localparam int TO_W = $clog2(FLUSH_TIMEOUT);

  fsm_state_t        state;
  fsm_state_t        state_next;
  logic [PC_W-1:0]   pack_cnt;
  logic [WORD_W-1:0] pack_word;
  logic [WORD_W-1:0] pack_next;
  logic              fifo_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [WC_W-1:0]   wc;
  logic [TO_W-1:0]   to_cnt;
  logic              packet_full;
  logic              timed_out;

  // Shift-in packing leaves the oldest sample in the top bits after four
  // samples, which is the order the W5500 clocks out on SPI.
  assign pack_next = {pack_word[WORD_W-SAMPLE_W-1:0], sample};
  assign fifo_wr   = sample_valid && enable &&
                     (pack_cnt == PC_W'(SAMPLES_PER_WORD - 1));
  assign pop       = (state == S_PUSH);

  stream_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (fifo_wr),
    .din   (pack_next),
    .rd_en (pop),
    .dout  (wiz_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_cnt  <= '0;
      pack_word <= '0;
    end else if (!enable) begin
      pack_cnt <= '0;
    end else if (sample_valid) begin
      pack_cnt  <= pack_cnt + PC_W'(1);
      pack_word <= pack_next;
    end
  end

  // A new drop outranks a clear in the same clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (fifo_wr && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

  assign packet_full = (wc == WC_W'(WORDS_PER_PACKET));
  assign timed_out   = (to_cnt == TO_W'(FLUSH_TIMEOUT - 1));

  // Every request is gated on wiz_is_available; in the last branch the FIFO
  // is known to be empty because the push branch was not taken.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (wiz_is_available) begin
          if (packet_full) begin
            state_next = S_FLUSH;
          end else if (!fifo_empty) begin
            state_next = S_PUSH;
          end else if ((wc != '0) && (timed_out || !enable)) begin
            state_next = S_FLUSH;
          end
        end
      end
      S_PUSH:  state_next = S_HOLD;
      S_FLUSH: state_next = S_HOLD;
      // The wiznet block raises its busy flag one clock after a request.
      S_HOLD:  state_next = S_WAIT;
      S_WAIT:  if (wiz_is_available) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wc           <= '0;
      to_cnt       <= '0;
      packets_sent <= '0;
    end else begin
      state <= state_next;
      if (state == S_PUSH) begin
        wc <= wc + WC_W'(1);
      end else if (state == S_FLUSH) begin
        wc           <= '0;
        packets_sent <= packets_sent + 16'd1;
      end
      // Only starved idle time counts toward the partial-packet timeout.
      if (pop || (state == S_FLUSH) || (wc == '0)) begin
        to_cnt <= '0;
      end else if ((state == S_IDLE) && fifo_empty && !timed_out) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  assign wiz_data_valid = (state == S_PUSH);
  assign wiz_flush      = (state == S_FLUSH);
  assign busy           = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_wiznet_udp_stream_sched.sv
module tb_wiznet_udp_stream_sched;

  localparam int FIFO_DEPTH = 16;
  localparam int WPP        = 4;
  localparam int FT         = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sample_valid;
  logic [11:0] sample;
  logic        overflow_clear;
  logic        wiz_is_available;
  logic        wiz_data_valid;
  logic [47:0] wiz_data;
  logic        wiz_flush;
  logic        overflow;
  logic [15:0] packets_sent;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wiznet_udp_stream_sched #(
    .FIFO_DEPTH       (FIFO_DEPTH),
    .WORDS_PER_PACKET (WPP),
    .FLUSH_TIMEOUT    (FT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .sample_valid     (sample_valid),
    .sample           (sample),
    .overflow_clear   (overflow_clear),
    .wiz_is_available (wiz_is_available),
    .wiz_data_valid   (wiz_data_valid),
    .wiz_data         (wiz_data),
    .wiz_flush        (wiz_flush),
    .overflow         (overflow),
    .packets_sent     (packets_sent),
    .busy             (busy)
  );

  // Wiznet model: unavailable 150 clks after a data pulse, 300 after a flush.
  int unsigned busy_timer;
  bit          hold_avail = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst)                  busy_timer <= 0;
    else if (wiz_data_valid)  busy_timer <= 150;
    else if (wiz_flush)       busy_timer <= 300;
    else if (busy_timer != 0) busy_timer <= busy_timer - 1;
  end
  assign wiz_is_available = (busy_timer == 0) && !hold_avail;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records pushed words and pulse timing.
  logic [47:0] push_q[$];
  int          push_cyc_q[$];
  int          push_count = 0;
  int          flush_count = 0;
  int          coincide_count = 0;
  int          last_flush_cyc = 0;
  int          pushes_at_last_flush = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (wiz_data_valid && wiz_flush) coincide_count++;
      if (wiz_data_valid) begin
        push_q.push_back(wiz_data);
        push_cyc_q.push_back(cyc);
        push_count++;
        $display("push  #%0d cyc=%0d data=%h", push_count, cyc, wiz_data);
      end
      if (wiz_flush) begin
        flush_count++;
        last_flush_cyc = cyc;
        pushes_at_last_flush = push_count;
        $display("flush #%0d cyc=%0d packets_sent=%0d", flush_count, cyc, packets_sent);
      end
    end
  end

  task automatic send_samples(input logic [11:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample       = base + 12'(i);
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_pushes(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (push_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_flushes(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (flush_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_quiet(input int bound, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && wiz_is_available) quiet++;
      else quiet = 0;
      if (quiet >= 8) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wiz_data_valid, wiz_flush, overflow, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got valid/flush/ovf/busy=%b expected 0000",
               {wiz_data_valid, wiz_flush, overflow, busy});
    end
    checks++;
    if (wiz_data !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", wiz_data);
    end
    checks++;
    if (packets_sent !== 16'd0) begin
      errors++;
      $display("FAIL reset_packets: got %0d expected 0", packets_sent);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pack_order();
    int p0, f0, t4;
    bit ok;
    p0 = push_count;
    f0 = flush_count;
    t4 = 0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample       = 12'(i + 1);
      if (i == 3) t4 = cyc;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    wait_pushes(p0 + 2, 1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pack_wait: got %0d pushes expected 2", push_count - p0);
    end
    checks++;
    if (push_q[p0] !== 48'h001002003004) begin
      errors++;
      $display("FAIL pack_word0: got %h expected 001002003004", push_q[p0]);
    end
    checks++;
    if (push_q[p0+1] !== 48'h005006007008) begin
      errors++;
      $display("FAIL pack_word1: got %h expected 005006007008", push_q[p0+1]);
    end
    checks++;
    if (push_cyc_q[p0] - t4 !== 2) begin
      errors++;
      $display("FAIL pack_latency: got %0d clks expected 2", push_cyc_q[p0] - t4);
    end
    enable = 1'b0;
    wait_quiet(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pack_quiet: got busy=%b expected idle", busy);
    end
    checks++;
    if (flush_count - f0 !== 1) begin
      errors++;
      $display("FAIL pack_flushes: got %0d expected 1", flush_count - f0);
    end
    checks++;
    if (packets_sent !== 16'd1) begin
      errors++;
      $display("FAIL pack_packets: got %0d expected 1", packets_sent);
    end
  endtask

  task automatic test_packet_flush();
    int p0, f0;
    bit ok;
    p0 = push_count;
    f0 = flush_count;
    enable = 1'b1;
    send_samples(12'h100, 16);
    wait_flushes(f0 + 1, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pkt_wait: got %0d flushes expected 1", flush_count - f0);
    end
    checks++;
    if (pushes_at_last_flush - p0 !== 4) begin
      errors++;
      $display("FAIL pkt_pushes_before_flush: got %0d expected 4", pushes_at_last_flush - p0);
    end
    checks++;
    if (push_q[p0+3] !== 48'h10C10D10E10F) begin
      errors++;
      $display("FAIL pkt_word3: got %h expected 10c10d10e10f", push_q[p0+3]);
    end
    enable = 1'b0;
    wait_quiet(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pkt_quiet: got busy=%b expected idle", busy);
    end
    checks++;
    if (flush_count - f0 !== 1) begin
      errors++;
      $display("FAIL pkt_flushes: got %0d expected 1", flush_count - f0);
    end
    checks++;
    if (packets_sent !== 16'd2) begin
      errors++;
      $display("FAIL pkt_packets: got %0d expected 2", packets_sent);
    end
  endtask

  task automatic test_timeout();
    int p0, f0;
    bit ok;
    p0 = push_count;
    f0 = flush_count;
    enable = 1'b1;
    send_samples(12'h300, 6);
    wait_flushes(f0 + 1, 2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_wait: got %0d flushes expected 1", flush_count - f0);
    end
    checks++;
    if (push_q[p0] !== 48'h300301302303) begin
      errors++;
      $display("FAIL to_word: got %h expected 300301302303", push_q[p0]);
    end
    // 1 hold + 150 wait + 1 return to idle, then FT idle clocks
    checks++;
    if (last_flush_cyc - push_cyc_q[p0] !== 152 + FT) begin
      errors++;
      $display("FAIL to_delay: got %0d clks expected %0d", last_flush_cyc - push_cyc_q[p0], 152 + FT);
    end
    enable = 1'b0;
    wait_quiet(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_quiet: got busy=%b expected idle", busy);
    end
    checks++;
    if (push_count - p0 !== 1) begin
      errors++;
      $display("FAIL to_pushes: got %0d expected 1", push_count - p0);
    end
    checks++;
    if (packets_sent !== 16'd3) begin
      errors++;
      $display("FAIL to_packets: got %0d expected 3", packets_sent);
    end
  endtask

  task automatic test_overflow();
    int p0, f0;
    bit ok;
    p0 = push_count;
    f0 = flush_count;
    hold_avail = 1'b1;
    enable = 1'b1;
    send_samples(12'h400, 4 * (FIFO_DEPTH + 1));
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    checks++;
    if ({busy, push_count - p0} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL ovf_held: got busy=%b pushes=%0d expected busy=1 pushes=0", busy, push_count - p0);
    end
    hold_avail = 1'b0;
    wait_pushes(p0 + FIFO_DEPTH, 8000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ovf_drain: got %0d pushes expected %0d", push_count - p0, FIFO_DEPTH);
    end
    wait_quiet(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ovf_quiet: got busy=%b expected idle", busy);
    end
    checks++;
    if (push_count - p0 !== FIFO_DEPTH) begin
      errors++;
      $display("FAIL ovf_pushes: got %0d expected %0d", push_count - p0, FIFO_DEPTH);
    end
    checks++;
    if (push_q[p0] !== 48'h400401402403) begin
      errors++;
      $display("FAIL ovf_first: got %h expected 400401402403", push_q[p0]);
    end
    checks++;
    if (push_q[p0+FIFO_DEPTH-1] !== 48'h43C43D43E43F) begin
      errors++;
      $display("FAIL ovf_last: got %h expected 43c43d43e43f", push_q[p0+FIFO_DEPTH-1]);
    end
    checks++;
    if (flush_count - f0 !== 4) begin
      errors++;
      $display("FAIL ovf_flushes: got %0d expected 4", flush_count - f0);
    end
    checks++;
    if ({overflow, packets_sent} !== {1'b1, 16'd7}) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b packets=%0d expected ovf=1 packets=7", overflow, packets_sent);
    end
    @(negedge clk);
    overflow_clear = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_enable_drop();
    int p0, f0;
    bit ok;
    p0 = push_count;
    f0 = flush_count;
    enable = 1'b1;
    send_samples(12'h500, 9);
    enable = 1'b0;
    wait_flushes(f0 + 1, 2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL en_wait: got %0d flushes expected 1", flush_count - f0);
    end
    checks++;
    if (pushes_at_last_flush - p0 !== 2) begin
      errors++;
      $display("FAIL en_pushes: got %0d expected 2", pushes_at_last_flush - p0);
    end
    checks++;
    if (push_q[p0+1] !== 48'h504505506507) begin
      errors++;
      $display("FAIL en_word1: got %h expected 504505506507", push_q[p0+1]);
    end
    // flush decided in the first idle clock after the second push completes
    checks++;
    if (last_flush_cyc - push_cyc_q[p0+1] !== 153) begin
      errors++;
      $display("FAIL en_flush_delay: got %0d clks expected 153", last_flush_cyc - push_cyc_q[p0+1]);
    end
    wait_quiet(2000, ok);
    enable = 1'b1;
    send_samples(12'h510, 4);
    wait_pushes(p0 + 3, 500, ok);
    checks++;
    if (push_q[p0+2] !== 48'h510511512513) begin
      errors++;
      $display("FAIL en_fresh_word: got %h expected 510511512513", push_q[p0+2]);
    end
    enable = 1'b0;
    wait_quiet(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL en_quiet: got busy=%b expected idle", busy);
    end
    checks++;
    if (packets_sent !== 16'd9) begin
      errors++;
      $display("FAIL en_packets: got %0d expected 9", packets_sent);
    end
  endtask

  task automatic test_reset_mid_push();
    int p0;
    bit ok;
    bit seen;
    hold_avail = 1'b1;
    enable = 1'b1;
    send_samples(12'h600, 6);
    hold_avail = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wiz_data_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstpush_reach: got no push expected push within 50 clks");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wiz_data_valid, wiz_flush, overflow, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rstpush_flags: got valid/flush/ovf/busy=%b expected 0000",
               {wiz_data_valid, wiz_flush, overflow, busy});
    end
    checks++;
    if ({wiz_data, packets_sent} !== 64'h0) begin
      errors++;
      $display("FAIL rstpush_values: got data=%h packets=%0d expected 0/0", wiz_data, packets_sent);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    p0 = push_count;
    send_samples(12'h700, 4);
    wait_pushes(p0 + 1, 200, ok);
    checks++;
    if (push_q[p0] !== 48'h700701702703) begin
      errors++;
      $display("FAIL rstpush_word: got %h expected 700701702703", push_q[p0]);
    end
    enable = 1'b0;
    wait_quiet(2000, ok);
    checks++;
    if (packets_sent !== 16'd1) begin
      errors++;
      $display("FAIL rstpush_packets: got %0d expected 1", packets_sent);
    end
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    sample_valid   = 1'b0;
    sample         = 12'h0;
    overflow_clear = 1'b0;
    test_reset();
    test_pack_order();
    test_packet_flush();
    test_timeout();
    test_overflow();
    test_enable_drop();
    test_reset_mid_push();
    checks++;
    if (coincide_count !== 0) begin
      errors++;
      $display("FAIL pulse_overlap: got %0d overlapping clks expected 0", coincide_count);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
